// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller.
// Writeback-select codes arrive on the ex/mem_wbsel ports.
// Forward-select codes are driven on fwd_sel toward the EX operand muxes.
package hazard_pkg;

  // Writeback select encodings. Cast to the port width at the point of use.
  localparam int unsigned WB_ALU  = 32'd0;
  localparam int unsigned WB_LOAD = 32'd1;
  localparam int unsigned WB_LONG = 32'd2;

  // Per-source EX operand select encodings
  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_MEM_ALU = 2'd1;
  localparam logic [1:0] FWD_WB_ALU  = 2'd2;
  localparam logic [1:0] FWD_WB_LOAD = 2'd3;

endpackage

// File: rtl/hazard_fwd_ctrl_scoreboard.sv
// Pending-write scoreboard for long-latency writebacks.
// Holds one bit per architectural register. If a set and a clear hit the
// same bit in one cycle, the set wins. The lookup ports report a pending
// bit only when it is not being released by this cycle's clear, because
// the clear is a regfile write-through and the reader can take the value now.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int RAW   = 5,
  parameter int NLOOK = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [RAW-1:0]         set_addr,
  input  logic                   clr_en,
  input  logic [RAW-1:0]         clr_addr,
  input  logic [NLOOK*RAW-1:0]   look_addr,
  output logic [NLOOK-1:0]       look_hit,
  output logic                   busy
);

  localparam int NREG = 2 ** RAW;

  logic [NREG-1:0] bits_r;
  logic [NREG-1:0] bits_nxt_s;

  // Next scoreboard state: apply the clear first, then the set (set wins).
  always_comb begin
    bits_nxt_s = bits_r;
    for (int r = 0; r < NREG; r++) begin
      bits_nxt_s[r] = (set_en && (set_addr == RAW'(r))) ? 1'b1 :
                      ((clr_en && (clr_addr == RAW'(r))) ? 1'b0 : bits_r[r]);
    end
  end

  // Lookup: a pending bit counts unless it is written back in this cycle.
  always_comb begin
    look_hit = {NLOOK{1'b0}};
    for (int k = 0; k < NLOOK; k++) begin
      look_hit[k] = bits_r[look_addr[k*RAW +: RAW]] &
                    ~(clr_en & (clr_addr == look_addr[k*RAW +: RAW]));
    end
  end

  // Scoreboard bits and the registered busy flag. The flag is computed from
  // the next state, so it lines up with the bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_r <= {NREG{1'b0}};
      busy   <= 1'b0;
    end else begin
      bits_r <= bits_nxt_s;
      busy   <= |bits_nxt_s;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard and forwarding controller.
// Compares each ID-stage source against the EX and MEM producers.
// Produces:
//   - a combinational stall;
//   - a per-source forward select, registered so that it lines up with the
//     instruction as it enters EX;
//   - RAW/WAW interlocks against long-latency writebacks pending in the
//     scoreboard.
// Optional: define HAZARD_PERF_EN to add the load-use and scoreboard stall
// counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int NSRC    = 2,
  parameter int RAW     = 5,
  parameter int WBSEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*RAW-1:0]  id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic                 id_regwr,
  input  logic [RAW-1:0]       id_rd,
  input  logic                 ex_valid,
  input  logic                 ex_regwr,
  input  logic [WBSEL_W-1:0]   ex_wbsel,
  input  logic [RAW-1:0]       ex_rd,
  input  logic                 mem_valid,
  input  logic                 mem_regwr,
  input  logic [WBSEL_W-1:0]   mem_wbsel,
  input  logic [RAW-1:0]       mem_rd,
  input  logic                 lw_done,
  input  logic [RAW-1:0]       lw_rd,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic                 sb_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_lu_stalls,
  output logic [31:0]          perf_sb_stalls
`endif
);

  logic [NSRC-1:0]     src_on_s;
  logic [NSRC-1:0]     ex_hit_s;
  logic [NSRC-1:0]     mem_hit_s;
  logic [NSRC-1:0]     lu_src_s;
  logic [NSRC-1:0]     exl_src_s;
  logic [NSRC-1:0]     raw_src_s;
  logic [NSRC*2-1:0]   nxt_sel_s;
  logic [NSRC:0]       look_hit_s;
  logic                sb_set_s;
  logic                waw_s;
  logic                lu_stall_s;
  logic                sb_stall_s;

  // Scoreboard set: a long op in EX that survives this cycle.
  assign sb_set_s = ex_valid & ex_regwr & (ex_wbsel == WBSEL_W'(WB_LONG)) &
                    (ex_rd != {RAW{1'b0}}) & ~flush;

  hazard_scoreboard #(
    .RAW   (RAW),
    .NLOOK (NSRC + 1)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (sb_set_s),
    .set_addr  (ex_rd),
    .clr_en    (lw_done),
    .clr_addr  (lw_rd),
    .look_addr ({id_rd, id_rs}),
    .look_hit  (look_hit_s),
    .busy      (sb_busy)
  );

  // Per-source qualifiers. Register 0 is never a hazard.
  always_comb begin
    src_on_s  = {NSRC{1'b0}};
    ex_hit_s  = {NSRC{1'b0}};
    mem_hit_s = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      src_on_s[i]  = id_valid & id_rs_used[i] & (id_rs[i*RAW +: RAW] != {RAW{1'b0}});
      ex_hit_s[i]  = ex_valid & ex_regwr & (ex_rd == id_rs[i*RAW +: RAW]);
      mem_hit_s[i] = mem_valid & mem_regwr & (mem_rd == id_rs[i*RAW +: RAW]);
    end
  end

  // Per-source forward and stall decisions. The EX producer, being the
  // youngest, takes priority over the MEM producer.
  always_comb begin
    nxt_sel_s = {NSRC*2{1'b0}};
    lu_src_s  = {NSRC{1'b0}};
    exl_src_s = {NSRC{1'b0}};
    raw_src_s = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      raw_src_s[i] = src_on_s[i] & look_hit_s[i];
      if (src_on_s[i] && ex_hit_s[i]) begin
        case (ex_wbsel)
          WBSEL_W'(WB_ALU):  nxt_sel_s[i*2 +: 2] = FWD_MEM_ALU;
          WBSEL_W'(WB_LOAD): lu_src_s[i]  = 1'b1;
          WBSEL_W'(WB_LONG): exl_src_s[i] = 1'b1;
          default:           nxt_sel_s[i*2 +: 2] = FWD_RF;
        endcase
      end else if (src_on_s[i] && mem_hit_s[i]) begin
        case (mem_wbsel)
          WBSEL_W'(WB_ALU):  nxt_sel_s[i*2 +: 2] = FWD_WB_ALU;
          WBSEL_W'(WB_LOAD): nxt_sel_s[i*2 +: 2] = FWD_WB_LOAD;
          default:           nxt_sel_s[i*2 +: 2] = FWD_RF;
        endcase
      end else begin
        nxt_sel_s[i*2 +: 2] = FWD_RF;
      end
    end
  end

  // Stall causes. A long op still in EX has not reached the scoreboard yet,
  // so its consumer is caught here and counted as a scoreboard stall.
  assign waw_s      = id_valid & id_regwr & look_hit_s[NSRC];
  assign lu_stall_s = |lu_src_s;
  assign sb_stall_s = (|exl_src_s) | (|raw_src_s) | waw_s;
  assign stall      = (lu_stall_s | sb_stall_s) & ~flush & rst_n;

  // Forward selects for the instruction entering EX. A flush or a bubble
  // entering EX gets the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel <= {NSRC*2{1'b0}};
    end else if (flush || stall) begin
      fwd_sel <= {NSRC*2{1'b0}};
    end else begin
      fwd_sel <= nxt_sel_s;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating stall-cause counters. A cycle with both causes bumps both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_stalls <= 32'd0;
      perf_sb_stalls <= 32'd0;
    end else begin
      if (lu_stall_s && !flush && (perf_lu_stalls != 32'hFFFF_FFFF)) begin
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      end else begin
        perf_lu_stalls <= perf_lu_stalls;
      end
      if (sb_stall_s && !flush && (perf_sb_stalls != 32'hFFFF_FFFF)) begin
        perf_sb_stalls <= perf_sb_stalls + 32'd1;
      end else begin
        perf_sb_stalls <= perf_sb_stalls;
      end
    end
  end
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised, registered successor to the pipeline hazard/forwarding unit.
- Compares each ID-stage source against producers in EX and MEM. Emits a combinational stall and a per-source forwarding select, registered at the ID→EX boundary, that the EX operand muxes consume directly.
- Adds a pending-write scoreboard for long-latency writebacks (multi-cycle unit), giving RAW and WAW interlocks that the single-cycle unit lacks.

Parameters:
- NSRC, 2, number of source operands per instruction (1..3).
- RAW, 5, register address width; NREG = 2**RAW.
- WBSEL_W, 2, width of wbsel encoding.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NSRC*RAW  source register numbers, source i at [i*RAW +: RAW]
- id_rs_used  in  NSRC  source i is actually read
- id_regwr  in  1  ID instruction writes id_rd
- id_rd  in  RAW  ID destination
- ex_valid, ex_regwr  in  1 each  EX producer qualifiers
- ex_wbsel  in  WBSEL_W  EX writeback select: 0=ALU, 1=load, 2=long-latency
- ex_rd  in  RAW  EX destination
- mem_valid, mem_regwr  in  1 each  MEM producer qualifiers
- mem_wbsel  in  WBSEL_W  MEM writeback select
- mem_rd  in  RAW  MEM destination
- lw_done  in  1  long-latency unit writes back this cycle (regfile write-through)
- lw_rd  in  RAW  long-latency destination
- flush  in  1  branch/exception kill of ID and EX
- stall  out  1  combinational; hold PC and IF/ID, bubble into EX
- fwd_sel  out  NSRC*2  registered; per-source EX select: 0=RF, 1=MEM ALU result, 2=WB ALU result, 3=WB load data
- sb_busy  out  1  registered; any scoreboard bit set

Behaviour:
- Reset (async, rst_n low): fwd_sel=0 for all sources, scoreboard cleared, sb_busy=0. stall drives 0 while in reset.
- Source i is considered only when id_valid & id_rs_used[i] & id_rs[i]!=0. Register 0 is never a hazard.
- EX match (ex_valid & ex_regwr & ex_rd==rs):
  - wbsel 0: next select = 1.
  - wbsel 1: load-use, so stall (one bubble; next cycle the producer is in MEM and the MEM rule applies).
  - wbsel 2: covered by scoreboard set; stall.
- MEM match (mem_valid & mem_regwr & mem_rd==rs, no EX match):
  - wbsel 0: next select = 2.
  - wbsel 1: next select = 3.
- EX match has priority over MEM match (youngest producer wins). WB-stage producers need no forwarding because the regfile is write-through.
- Scoreboard, NREG bits:
  - Set bit ex_rd when ex_valid & ex_regwr & ex_wbsel==2 & ex_rd!=0 & !flush.
  - Clear bit lw_rd on lw_done.
  - Set and clear of the same bit in one cycle: set wins.
- Scoreboard stall when either holds:
  - RAW: a considered source hits a pending bit and is not (lw_done & lw_rd==rs).
  - WAW: id_valid & id_regwr & id_rd hits a pending bit with the same lw_done exception.
- stall = OR of all load-use and scoreboard conditions, gated with !flush.
- fwd_sel register update:
  - flush: load 0.
  - else stall: load 0; the bubble entering EX must not forward.
  - else: load the next select.
  - Latency: decision in ID cycle N appears on fwd_sel in cycle N+1, aligned with the instruction in EX.
- flush does not clear already-set scoreboard bits (issued long ops still complete). flush in the same cycle as a set: set suppressed.
- sb_busy = OR of the scoreboard bits, registered.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds 32-bit outputs perf_lu_stalls and perf_sb_stalls, reset to 0.
  - perf_lu_stalls increments each cycle with a load-use stall.
  - perf_sb_stalls increments each cycle with a scoreboard stall.
  - A cycle with both causes increments both.
  - Counters saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; function is otherwise identical.

Decomposition:
- Shared package hazard_pkg: wbsel constants WB_ALU=0, WB_LOAD=1, WB_LONG=2, and fwd_sel constants FWD_RF, FWD_MEM_ALU, FWD_WB_ALU, FWD_WB_LOAD.
- Sub-module hazard_scoreboard: NREG-bit set/clear vector with a combinational lookup port for NSRC+1 addresses. It is instantiated once.

Test Plan:
- ALU→ALU: EX add x5 (wbsel 0), ID reads rs1=x5 → stall=0, next cycle fwd_sel[1:0]=1.
- Load-use: EX lw x7, ID rs2=x7 → stall=1 for exactly one cycle, then fwd_sel[3:2]=3.
- Priority: EX writes x3 (ALU), MEM writes x3 (load), ID rs1=x3 → fwd_sel[1:0]=1, no stall.
- x0: EX lw x0, ID rs1=x0 → stall=0, fwd_sel=0.
- Scoreboard:
  - Issue a long op to x9 → sb_busy=1.
  - ID reads x9 → stall held until the lw_done cycle with lw_rd=9, when stall=0 in that same cycle.
  - ID writing x9 while it is pending also stalls (WAW).
- Flush/reset:
  - flush while stalled → stall=0, fwd_sel=0, pending bit kept.
  - rst_n low mid-pending → all bits clear asynchronously; HAZARD_PERF_EN counters return to 0.
